serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-in, serial-out asynchronous-style transmitter. It accepts a word through a valid/ready handshake and shifts it out LSB first on a single line. Each frame has one start bit, WIDTH data bits, an optional even-parity bit and one stop bit. Every bit is held for CLKS_PER_BIT clock cycles. The block sits on the outbound side of the datapath and pairs with the capture/receive registers already in the design.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CLKS_PER_BIT, 16, clock cycles per serial bit (>=1)
PARITY_EN, 0, 1 = append an even-parity bit after the data bits; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk
d  input  WIDTH  word to send; sampled only at the accept edge
valid  input  1  sender has a word on d
ready  output  1  block can accept a word; high only in IDLE
tx  output  1  serial line, registered, idle-high
busy  output  1  high while a frame is in progress (any state other than IDLE)
done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset: any rising edge with reset=0 forces state IDLE on the next cycle.
  - Outputs after that edge: tx=1, busy=0, done=0, ready=1.
  - Bit counter, baud counter and shift register are cleared.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Accept: at a rising edge with state==IDLE && valid==1.
  - d is loaded into the shift register.
  - Parity is computed as the XOR of d.
  - State becomes START.
  - The tx=0 start bit appears on the cycle right after the accept edge, so latency is 1 cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 within each bit.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - The bit advances when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- DATA: tx = shift register bit 0.
  - On each bit advance the register shifts right.
  - The bit index increments from 0 to WIDTH-1.
  - After bit WIDTH-1 the state moves to PARITY, or to STOP if PARITY_EN=0.
- PARITY: tx = XOR of the captured word, which gives even parity over data plus parity bit.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the final STOP cycle edge, state returns to IDLE and done is asserted for exactly 1 cycle, coinciding with the first IDLE cycle.
- Frame length: (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames: ready is high only in IDLE. A new word can be accepted on the done cycle (valid held high), so the next start bit begins 1 cycle after the previous stop bit ends.
- valid while busy: ignored. No acceptance, no queuing.
- d changes while busy: no effect on the frame in progress.
- Reset mid-frame: the frame is aborted, tx returns to 1 on the next cycle, no done pulse is produced and no partial bits are resumed.
- CLKS_PER_BIT=1 is legal: each bit lasts 1 cycle.
- Counter widths: $clog2(CLKS_PER_BIT) bits for the baud counter and $clog2(WIDTH) bits for the bit index, each with a minimum of 1 bit.

Decomposition:
- Package serial_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1
  - The same package is shared with the future receiver.
- One sub-module: serial_baud_gen (parameter CLKS_PER_BIT).
  - Ports: clk, reset, en, tick.
  - Provides a free-running bit-period counter that restarts when en is low.
  - tick pulses on the last cycle of each bit period.
- The FSM, shift register and parity logic stay in serial_tx.

Test Plan:
(All scenarios use WIDTH=8, CLKS_PER_BIT=4.)
- Reset: hold reset=0 for 2 edges with valid=1 and d=8'hFF -> tx=1, busy=0, ready=1, done=0; no frame starts.
- Single frame, PARITY_EN=0: accept 8'hA5 -> tx over 4-cycle bits reads 0, 1,0,1,0,0,1,0,1, 1 (40 cycles total).
  - done pulses once on cycle 41.
  - busy=1 for exactly 40 cycles.
- Parity, PARITY_EN=1: send 8'h07 -> parity bit 1. Send 8'h03 -> parity bit 0. Frame length is 44 cycles.
- Busy rejection: during the frame for 8'h3C, pulse valid with d=8'hFF -> ready stays 0 and the transmitted bits still match 8'h3C.
- Back-to-back: hold valid=1 with 8'h55 then 8'hAA -> second accept happens on the done cycle; the second start bit begins 1 cycle after the first stop bit ends.
- Mid-frame reset: assert reset=0 for 1 edge during data bit 3 -> tx=1 and busy=0 on the next cycle, no done pulse; the next accepted word (8'h81) transmits correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial line blocks (transmitter now, receiver later).
//   tx_state_t  : transmitter frame state
//   *_LEVEL     : line levels for idle, start bit and stop bit
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period timer for the serial transmitter.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   en    : count while high; counter is held at zero while low
//   tick  : high on the last cycle of each CLKS_PER_BIT-cycle bit period
module serial_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Holding the counter at zero while disabled means the first period
    // after enable is always a full CLKS_PER_BIT cycles long.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter. Frame: start bit, WIDTH data bits
// LSB first, optional even-parity bit, one stop bit; each bit lasts
// CLKS_PER_BIT cycles.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   d     : word to send, sampled on the accept edge
//   valid : sender has a word on d
//   ready : block can accept a word (IDLE only)
//   tx    : registered serial line, idle high
//   busy  : frame in progress
//   done  : one-cycle pulse on the first IDLE cycle after the stop bit
//
// Handshake: a word is transferred on any rising edge where valid and ready
// are both high. valid while ready is low is ignored (no queuing), and d is
// not looked at outside the transfer edge.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    tx_state_t        state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             par, par_next;
    logic             tx_next;
    logic             done_next;
    logic             tick;

    serial_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            par   <= 1'b0;
            tx    <= IDLE_LEVEL;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            idx   <= idx_next;
            par   <= par_next;
            tx    <= tx_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = idx;
        par_next   = par;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (valid) begin
                    shreg_next = d;
                    par_next   = ^d;
                    idx_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_next = shreg >> 1;
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered: its next value is taken from the next state so the
    // line level changes on the same edge as the state does.
    always_comb begin
        tx_next = IDLE_LEVEL;
        case (state_next)
            IDLE:    tx_next = IDLE_LEVEL;
            START:   tx_next = START_LEVEL;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_next;
            STOP:    tx_next = STOP_LEVEL;
            default: tx_next = IDLE_LEVEL;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  localparam int W   = 8;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // channel 0: no parity, channel 1: even parity
  logic [W-1:0] d0, d1;
  logic [1:0]   valid_v;
  logic [1:0]   ready_v, tx_v, busy_v, done_v;

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .d(d0), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .d(d1), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [1:0] abort_exp = 2'b00;
  int prev_end[2];
  int last_gap[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: line level at cycle c of a frame carrying word w.
  function automatic logic exp_line(input logic [W-1:0] w, input int c, input bit par);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
    if (par && b == W + 1) return ($countones(w) % 2) == 1;
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  task automatic run_monitor(input int ch);
    logic [W-1:0] w;
    int len;
    bit par;
    bit aborted;
    par = (ch == 1);
    len = (2 + W + (par ? 1 : 0)) * CPB;
    prev_end[ch] = -100;
    wait (mon_en);
    @(negedge clk);
    forever begin
      if (busy_v[ch]) begin
        last_gap[ch] = cyc - prev_end[ch];
        aborted = 1'b0;
        if (ch == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0) begin
          check($sformatf("ch%0d unexpected frame", ch), 1, 0);
          w = '0;
        end else begin
          w = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        end
        for (int c = 0; c < len; c++) begin
          if (!busy_v[ch]) begin
            if (abort_exp[ch]) begin
              abort_exp[ch] = 1'b0;
            end else begin
              check($sformatf("ch%0d busy dropped early", ch), c, len);
            end
            aborted = 1'b1;
            break;
          end
          check($sformatf("ch%0d tx word %0h cyc %0d", ch, w, c), tx_v[ch], exp_line(w, c, par));
          if (c == len - 1) prev_end[ch] = cyc;
          @(negedge clk);
        end
        if (!aborted) begin
          check($sformatf("ch%0d done pulse", ch), done_v[ch], 1);
          check($sformatf("ch%0d busy on done cycle", ch), busy_v[ch], 0);
          check($sformatf("ch%0d tx on done cycle", ch), tx_v[ch], 1);
          @(negedge clk);
        end
      end else begin
        if (done_v[ch]) check($sformatf("ch%0d spurious done", ch), done_v[ch], 0);
        if (tx_v[ch] !== 1'b1) check($sformatf("ch%0d idle tx", ch), tx_v[ch], 1);
        @(negedge clk);
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  // ---------------- driver tasks ----------------
  task automatic send(input int ch, input logic [W-1:0] w);
    bit acc;
    int n;
    n = 0;
    if (ch == 0) d0 = w; else d1 = w;
    valid_v[ch] = 1'b1;
    forever begin
      @(negedge clk);
      acc = ready_v[ch];
      if (acc) begin
        if (ch == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
      end
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check($sformatf("ch%0d accept timeout", ch), 0, 1);
        break;
      end
    end
    valid_v[ch] = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q0.size() != 0 || exp_q1.size() != 0 || busy_v != 2'b00) begin
      @(posedge clk);
      n++;
      if (n > 2000) begin
        check("drain timeout", 0, 1);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    valid_v = 2'b11;
    d0 = 8'hFF;
    d1 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("reset tx ch%0d", ch), tx_v[ch], 1);
      check($sformatf("reset busy ch%0d", ch), busy_v[ch], 0);
      check($sformatf("reset ready ch%0d", ch), ready_v[ch], 1);
      check($sformatf("reset done ch%0d", ch), done_v[ch], 0);
    end
    valid_v = 2'b00;
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no frame after reset", busy_v, 0);

    // single frame, no parity
    send(0, 8'hA5);
    wait_drained();

    // parity frames
    send(1, 8'h07);
    send(1, 8'h03);
    wait_drained();

    // valid while busy is ignored and d changes have no effect
    send(0, 8'h3C);
    repeat (10) @(posedge clk);
    #1;
    valid_v[0] = 1'b1;
    d0 = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("ready low while busy", ready_v[0], 0);
    end
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    wait_drained();

    // back-to-back: second accept on the done cycle
    send(0, 8'h55);
    send(0, 8'hAA);
    repeat (2) @(negedge clk);
    check("back-to-back gap", last_gap[0], 2);
    wait_drained();

    // reset during data bit 3
    send(0, 8'hC3);
    repeat (17) @(posedge clk);
    #1;
    abort_exp[0] = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort tx", tx_v[0], 1);
    check("abort busy", busy_v[0], 0);
    check("abort done", done_v[0], 0);
    check("abort seen by monitor", abort_exp[0], 0);
    repeat (2) @(posedge clk);
    #1;
    send(0, 8'h81);
    wait_drained();

    // randomized words and gaps on both channels
    for (int i = 0; i < 6; i++) begin
      send(0, W'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(1, W'($urandom_range(0, 255)));
      wait_drained();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
